// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/halfword/word load-store controller in front of a
// single-port word memory whose read data is combinational. Sub-word stores
// are done as read-modify-write (RD then WR). Byte lanes are big-endian.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, misaligned halfword
// and word requests complete immediately with resp_err=1 and no memory
// access; when undefined, halfword/word ops silently drop the low address bits.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_t;

  state_t      state, state_next;
  op_t         op_in, op_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic        err_q;
  logic        accept, misaligned, store_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, merged;

  assign op_in     = op_t'(req_op);
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign store_q   = op_q inside {OP_SB, OP_SH, OP_SW};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((op_in inside {OP_LH, OP_LHU, OP_SH}) && req_addr[0]) ||
                      ((op_in inside {OP_LW, OP_SW}) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture, read-word capture and the held load result.
  always_ff @(posedge clk) begin
    // NOTE: only the flags that reach the outputs are reset; op/addr/data
    // captures are always written before they are used.
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= misaligned;
      end
      if (state == RD) begin
        word_q <= mem_rdata;
        if (!store_q) rdata_q <= load_ext;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (misaligned)           state_next = RESP;
        else if (op_in == OP_SW)  state_next = WR;
        else                      state_next = RD;
      end
      RD:   state_next = (op_q inside {OP_SB, OP_SH}) ? WR : RESP;
      WR:   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Select the addressed big-endian lane of the read word and extend it.
  always_comb begin
    lane_b = mem_rdata[31:24];
    case (addr_q[1:0])
      2'd0: lane_b = mem_rdata[31:24];
      2'd1: lane_b = mem_rdata[23:16];
      2'd2: lane_b = mem_rdata[15:8];
      2'd3: lane_b = mem_rdata[7:0];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h   = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    load_ext = mem_rdata;
    case (op_q)
      OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_ext = {24'h0, lane_b};
      OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_ext = {16'h0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace the addressed lane of the captured read word for SB/SH.
  always_comb begin
    merged = word_q;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = word_q;
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  // Memory port drive; enables are killed combinationally by reset.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == RD || state == WR) begin
      mem_ce   = !rst;
      mem_addr = {addr_q[31:2], 2'b00};
    end
    if (state == WR) begin
      mem_we    = !rst;
      mem_wdata = (op_q == OP_SW) ? wdata_q : merged;
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = ((state == RESP) && (store_q || err_q)) ? '0 : rdata_q;

endmodule
